iic_slave: RTL

I2C target (slave) responder that answers the team's I2C master on the same two-wire bus. It holds an internal byte-addressed register file and implements EEPROM-style byte write, sequential write, current-address read, random read (repeated START) and sequential read. SCL and SDA are oversampled on the system clock; the block only ever pulls SDA low or releases it.

---
 rtl/iic_slave.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/iic_slave.sv
// iic_slave: I2C target with a byte-addressed register file.
// Supports byte/sequential write, current-address, random and sequential read.
// SCL/SDA are oversampled on I_clk; SDA is only ever pulled low or released.
// Optional: define IIC_SLAVE_GLITCH_FILTER_EN for a 3-sample agreement filter
// on both synchronized lines (input latency 2 -> 5 cycles).
`timescale 1ns/1ps
module iic_slave #(
  parameter logic [6:0]  DEV_ADDR  = 7'b1010_000,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned SDA_HOLD  = 10
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_scl,
  inout  wire logic  IO_sda,
  output logic       O_wr_valid,
  output logic [7:0] O_wr_addr,
  output logic [7:0] O_wr_data,
  output logic       O_busy
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [15:0] HOLD_LOAD = (SDA_HOLD > 0) ? 16'(SDA_HOLD - 1) : 16'd0;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR_S, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_line, sda_line;
  logic          scl_prev, sda_prev;
  logic          scl_rise, scl_fall, start_det, stop_det;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [7:0]    rx_byte;
  logic [7:0]    tx;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [MEM_DEPTH];
  logic          rw;
  logic          ack_seen;
  logic          sda_oe;
  logic          pend;
  logic          pend_val;
  logic [15:0]   hold_cnt;

  // Release is combinational on reset so SDA frees up without waiting for a clock.
  assign IO_sda = (sda_oe && !I_rst) ? 1'b0 : 1'bz;

  // Two-flop synchronizers for both bus lines.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], I_scl};
      sda_sync <= {sda_sync[0], IO_sda};
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  // Line output follows only when the current and two previous samples agree.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_line <= 1'b1;
      sda_line <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      if (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) scl_line <= scl_sync[1];
      if (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) sda_line <= sda_sync[1];
    end
  end
`else
  assign scl_line = scl_sync[1];
  assign sda_line = sda_sync[1];
`endif

  // Previous-sample registers for edge detection.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_line;
      sda_prev <= sda_line;
    end
  end

  assign scl_rise  = scl_line & ~scl_prev;
  assign scl_fall  = ~scl_line & scl_prev;
  assign start_det = scl_line & scl_prev & sda_prev & ~sda_line;
  assign stop_det  = scl_line & scl_prev & ~sda_prev & sda_line;
  assign rx_byte   = {shreg, sda_line};

  // Protocol FSM, register file, and delayed SDA drive.
  // ACK states cover the fall ending bit 7 (drive), the ACK-slot rise, and the
  // fall ending bit 8; ack_seen tells the two falls apart.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      ack_seen   <= 1'b0;
      sda_oe     <= 1'b0;
      pend       <= 1'b0;
      pend_val   <= 1'b0;
      hold_cnt   <= '0;
      O_wr_valid <= 1'b0;
      O_wr_addr  <= '0;
      O_wr_data  <= '0;
      O_busy     <= 1'b0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      O_wr_valid <= 1'b0;
      if (pend) begin
        if (hold_cnt == '0) begin
          sda_oe <= pend_val;
          pend   <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 16'd1;
        end
      end

      if (start_det) begin
        state   <= DEV_ADDR_S;
        bit_cnt <= '0;
        O_busy  <= 1'b0;
        sda_oe  <= 1'b0;
        pend    <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        O_busy  <= 1'b0;
        sda_oe  <= 1'b0;
        pend    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEV_ADDR_S, WORD_ADDR, WR_DATA: begin
            if (scl_rise) begin
              shreg <= rx_byte[6:0];
              if (bit_cnt == 4'd7) begin
                bit_cnt  <= 4'd8;
                ack_seen <= 1'b0;
                if (state == DEV_ADDR_S) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state  <= DEV_ACK;
                    rw     <= rx_byte[0];
                    O_busy <= 1'b1;
                  end else begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                  end
                end else if (state == WORD_ADDR) begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= WORD_ACK;
                end else begin
                  mem[ptr]   <= rx_byte;
                  O_wr_valid <= 1'b1;
                  O_wr_addr  <= 8'(ptr);
                  O_wr_data  <= rx_byte;
                  ptr        <= ptr + 1'b1;
                  state      <= WR_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          DEV_ACK, WORD_ACK, WR_ACK: begin
            if (scl_rise) ack_seen <= 1'b1;
            if (scl_fall) begin
              pend     <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              if (!ack_seen) begin
                pend_val <= 1'b1;
              end else begin
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
                if (state == DEV_ACK && rw) begin
                  state    <= RD_DATA;
                  tx       <= mem[ptr];
                  pend_val <= ~mem[ptr][7];
                end else begin
                  state    <= (state == DEV_ACK) ? WORD_ADDR : WR_DATA;
                  pend_val <= 1'b0;
                end
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              tx <= {tx[6:0], 1'b0};
              if (bit_cnt == 4'd7) begin
                state    <= RD_ACK;
                bit_cnt  <= 4'd8;
                ack_seen <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            if (scl_fall) begin
              pend     <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              pend_val <= ~tx[7];
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_line) begin
                ack_seen <= 1'b1;
                ptr      <= ptr + 1'b1;
              end else begin
                state   <= IDLE;
                bit_cnt <= '0;
                O_busy  <= 1'b0;
                sda_oe  <= 1'b0;
                pend    <= 1'b0;
              end
            end
            if (scl_fall) begin
              pend     <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              if (!ack_seen) begin
                pend_val <= 1'b0;
              end else begin
                state    <= RD_DATA;
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
                tx       <= mem[ptr];
                pend_val <= ~mem[ptr][7];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
